// File: rtl/td4_prog_loader_if.sv
// Pin-side bus of the TD4 program loader: load/run requests, the strobed
// byte input, the CPU fetch port, and the loader status outputs.
interface td4_prog_loader_if;
  logic       load_req;
  logic       run_req;
  logic [7:0] data_in;
  logic       data_strobe;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       cpu_run;
  logic       loading;
  logic       load_done;
  logic [4:0] byte_count;
  logic [7:0] checksum;

  // Driver side: top-level pins plus the CPU program counter.
  modport master (
    output load_req, run_req, data_in, data_strobe, rom_addr,
    input  rom_data, cpu_run, loading, load_done, byte_count, checksum
  );

  // Loader side.
  modport slave (
    input  load_req, run_req, data_in, data_strobe, rom_addr,
    output rom_data, cpu_run, loading, load_done, byte_count, checksum
  );
endinterface

// File: rtl/td4_prog_loader.sv
// TD4 program loader: captures up to 16 strobed bytes into a 16x8 flop
// array, serves the array to the CPU fetch port, and gates the CPU so it
// only runs once a program has been loaded and a run is requested.
module td4_prog_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  td4_prog_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_LOADED = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev_q;
  logic                     strobe_pulse;
  logic                     wr_en;
  logic                     load_enter;
  logic [15:0][7:0]         mem_q;
  logic [3:0]               wr_addr_q;
  logic [4:0]               byte_count_q;
  logic [7:0]               checksum_q;

  // Bring the asynchronous strobe into the clk domain, then keep one
  // previous sample so a long-held level yields a single edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_strobe};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  // An edge arriving on the same cycle load_req drops is discarded.
  assign wr_en        = (state_q == S_LOAD) && bus.load_req && strobe_pulse;
  assign load_enter   = (state_d == S_LOAD) && (state_q != S_LOAD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; load_req wins over run_req everywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load_req)     state_d = S_LOAD;
        else if (bus.run_req) state_d = S_RUN;
      end
      S_LOAD: begin
        if (!bus.load_req)                       state_d = S_LOADED;
        else if (wr_en && byte_count_q == 5'd15) state_d = S_LOADED;
      end
      S_LOADED: begin
        if (bus.load_req)     state_d = S_LOAD;
        else if (bus.run_req) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.load_req)     state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program array and load bookkeeping. Entering LOAD restarts the count
  // and checksum but leaves old array contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '0;
      wr_addr_q    <= '0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else if (load_enter) begin
      wr_addr_q    <= '0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr_q] <= bus.data_in;
      wr_addr_q        <= wr_addr_q + 4'd1;
      byte_count_q     <= byte_count_q + 5'd1;
      checksum_q       <= checksum_q + bus.data_in;
    end
  end

  assign bus.rom_data   = mem_q[bus.rom_addr];
  assign bus.cpu_run    = (state_q == S_RUN);
  assign bus.loading    = (state_q == S_LOAD);
  assign bus.load_done  = (state_q == S_LOADED);
  assign bus.byte_count = byte_count_q;
  assign bus.checksum   = checksum_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: directed scenarios followed by random
// load/run/stray-strobe operations, all checked against a transaction-level
// model of the loader (state, byte list, count, checksum).
module tb_td4_prog_loader;
  localparam int SYNC_STAGES = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_LOADED = 2, M_RUN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  td4_prog_loader_if bus ();
  td4_prog_loader #(.SYNC_STAGES(SYNC_STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference model
  int         m_st;
  int         m_cnt;
  logic [7:0] m_cs;
  logic [7:0] m_mem [16];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    m_st = M_IDLE; m_cnt = 0; m_cs = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  endfunction

  function automatic void m_enter_load();
    m_st = M_LOAD; m_cnt = 0; m_cs = 8'h00;
  endfunction

  // One clock edge with the request levels l, r.
  function automatic void m_edge(input bit l, input bit r);
    case (m_st)
      M_IDLE:   if (l) m_enter_load(); else if (r) m_st = M_RUN;
      M_LOAD:   if (!l) m_st = M_LOADED;
      M_LOADED: if (l) m_enter_load(); else if (r) m_st = M_RUN;
      default:  if (l) m_enter_load();
    endcase
  endfunction

  // One byte arriving while the loader is in LOAD.
  function automatic void m_write(input logic [7:0] b);
    m_mem[m_cnt] = b;
    m_cnt++;
    m_cs = m_cs + b;
    if (m_cnt == 16) m_st = M_LOADED;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".loading"},   32'(bus.loading),    32'(m_st == M_LOAD));
    chk({tag, ".load_done"}, 32'(bus.load_done),  32'(m_st == M_LOADED));
    chk({tag, ".cpu_run"},   32'(bus.cpu_run),    32'(m_st == M_RUN));
    chk({tag, ".count"},     32'(bus.byte_count), 32'(m_cnt));
    chk({tag, ".csum"},      32'(bus.checksum),   32'(m_cs));
  endtask

  task automatic check_rom(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.rom_addr = 4'(a);
      #1;
      chk($sformatf("%s.rom[%0d]", tag, a), 32'(bus.rom_data), 32'(m_mem[a]));
    end
  endtask

  // Apply request levels for one edge, then check outputs right after it.
  task automatic set_req(input bit l, input bit r, input string tag);
    @(negedge clk);
    bus.load_req = l;
    bus.run_req  = r;
    @(posedge clk);
    m_edge(l, r);
    #1;
    check_outs(tag);
  endtask

  // Strobe one byte; len 1 gives a one-cycle pulse, otherwise held 4 cycles.
  // Checks the count is untouched at E1 and updated exactly at E2. When the
  // 16th byte lands, load_req is dropped so LOADED is held.
  task automatic strobe_byte(input logic [7:0] b, input int len, input string tag);
    bit w;
    @(negedge clk);
    bus.data_in     = b;
    bus.data_strobe = 1'b1;
    w = (m_st == M_LOAD) && bus.load_req;
    @(posedge clk);                       // E0
    if (len == 1) begin
      @(negedge clk);
      bus.data_strobe = 1'b0;
    end
    @(posedge clk);                       // E1
    #1;
    chk({tag, ".e1_count"}, 32'(bus.byte_count), 32'(m_cnt));
    @(posedge clk);                       // E2
    if (w) m_write(b);
    #1;
    check_outs({tag, ".e2"});
    if (w && m_cnt == 16) bus.load_req = 1'b0;
    @(negedge clk);
    bus.data_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_bytes(input int n, input string tag);
    set_req(1'b1, 1'b0, {tag, ".enter"});
    for (int i = 0; i < n; i++) strobe_byte(8'($urandom_range(0, 255)), 3, tag);
    if (bus.load_req) set_req(1'b0, 1'b0, {tag, ".exit"});
  endtask

  initial begin
    bus.load_req = 1'b0; bus.run_req = 1'b0; bus.data_in = 8'h00;
    bus.data_strobe = 1'b0; bus.rom_addr = 4'h0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("reset");
    check_rom("reset");

    // Both requests in IDLE: load wins.
    set_req(1'b1, 1'b1, "both_req");
    chk("both_req.loading", 32'(bus.loading), 32'd1);
    set_req(1'b1, 1'b0, "hold_load");

    // Full load 0x00..0x0F.
    for (int i = 0; i < 16; i++) strobe_byte(8'(i), 3, "full");
    chk("full.load_done", 32'(bus.load_done), 32'd1);
    chk("full.count", 32'(bus.byte_count), 32'd16);
    chk("full.csum", 32'(bus.checksum), 32'h78);
    bus.rom_addr = 4'd5;
    #1;
    chk("full.rom5", 32'(bus.rom_data), 32'h05);
    set_req(1'b0, 1'b1, "run");
    chk("run.cpu_run", 32'(bus.cpu_run), 32'd1);
    set_req(1'b0, 1'b0, "run_hold");

    // Stray strobe while running.
    strobe_byte(8'h5A, 3, "stray_run");
    check_rom("stray_run");

    // Reload from RUN.
    set_req(1'b1, 1'b0, "reload");
    chk("reload.cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("reload.loading", 32'(bus.loading), 32'd1);
    chk("reload.count", 32'(bus.byte_count), 32'd0);
    for (int i = 0; i < 16; i++) strobe_byte(8'hFF, 3, "ff");
    strobe_byte(8'h11, 3, "stray_loaded");

    // Partial load over the 0xFF image.
    set_req(1'b1, 1'b0, "part.enter");
    strobe_byte(8'hA1, 3, "part");
    strobe_byte(8'hB2, 3, "part");
    strobe_byte(8'hC3, 3, "part");
    set_req(1'b0, 1'b0, "part.exit");
    chk("part.load_done", 32'(bus.load_done), 32'd1);
    chk("part.count", 32'(bus.byte_count), 32'd3);
    chk("part.csum", 32'(bus.checksum), 32'h16);
    bus.rom_addr = 4'd2;
    #1;
    chk("part.rom2", 32'(bus.rom_data), 32'hC3);
    bus.rom_addr = 4'd3;
    #1;
    chk("part.rom3", 32'(bus.rom_data), 32'hFF);

    // Checksum wrap.
    set_req(1'b1, 1'b0, "wrap.enter");
    strobe_byte(8'h80, 3, "wrap");
    strobe_byte(8'h90, 3, "wrap");
    set_req(1'b0, 1'b0, "wrap.exit");
    chk("wrap.csum", 32'(bus.checksum), 32'h10);

    // One-cycle pulse must write exactly once.
    set_req(1'b1, 1'b0, "pulse.enter");
    strobe_byte(8'h3C, 1, "pulse");
    set_req(1'b0, 1'b0, "pulse.exit");
    chk("pulse.count", 32'(bus.byte_count), 32'd1);
    check_rom("pulse");

    // Random operations.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: begin load_bytes($urandom_range(1, 16), "rnd_load"); check_rom("rnd_load"); end
        1: begin set_req(1'b0, 1'b1, "rnd_run"); set_req(1'b0, 1'b0, "rnd_run0"); end
        2: begin strobe_byte(8'($urandom_range(0, 255)), 3, "rnd_stray"); check_rom("rnd_stray"); end
        3: begin set_req(1'b1, 1'b0, "rnd_empty"); set_req(1'b0, 1'b0, "rnd_empty0"); end
        default: begin
          set_req(1'b1, 1'b0, "rnd_pulse");
          strobe_byte(8'($urandom_range(0, 255)), 1, "rnd_pulse");
          set_req(1'b0, 1'b0, "rnd_pulse0");
        end
      endcase
    end

    // Asynchronous reset while running.
    set_req(1'b0, 1'b1, "pre_rst");
    set_req(1'b0, 1'b0, "pre_rst0");
    chk("pre_rst.cpu_run", 32'(bus.cpu_run), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst.cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("rst.count", 32'(bus.byte_count), 32'd0);
    chk("rst.csum", 32'(bus.checksum), 32'h00);
    check_outs("rst");
    check_rom("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray strobe in IDLE.
    strobe_byte(8'h77, 3, "stray_idle");
    check_rom("stray_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/td4_prog_loader.md
# td4_prog_loader

Program-memory writer for the 4-bit CPU core: receives up to 16 instruction bytes over a strobed parallel pin interface, stores them in a 16×8 flop array, and serves that array to the CPU's instruction fetch port. It also gates the CPU: the core is held stopped while a program is being loaded and released only on request. The block sits between the top-level pins and the CPU core's instruction/address interface.

## Interface
- SYNC_STAGES, 2, synchronizer depth for the asynchronous `data_strobe` pin (minimum 2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  level; high requests (re)load mode; already synchronous to clk
- run_req  in  1  level; high requests the CPU to run; already synchronous to clk
- data_in  in  8  program byte; must be stable while the strobe edge is processed
- data_strobe  in  1  asynchronous; each rising edge delivers one byte
- rom_addr  in  4  CPU program counter
- rom_data  out  8  instruction at `rom_addr`, combinational read of the array
- cpu_run  out  1  registered; high lets the CPU advance
- loading  out  1  registered; high in LOAD state
- load_done  out  1  registered; high in LOADED state
- byte_count  out  5  registered; bytes written in current/last load, 0..16
- checksum  out  8  registered; mod-256 sum of bytes written in current/last load

## Operation
- States: IDLE, LOAD, LOADED, RUN.
- Reset (async, immediate): state IDLE; all 16 array entries 0x00; write address 0; byte_count 0; checksum 0x00; cpu_run 0; loading 0; load_done 0; synchronizer and edge-detect flops 0.
- IDLE: load_req=1 → LOAD; else run_req=1 → RUN. load_req has priority in every state.
- Entering LOAD: write address, byte_count, checksum cleared to 0 on the transition edge. Array contents are not cleared.
- LOAD: each detected strobe edge writes `data_in` to array[write address], increments write address and byte_count, adds `data_in` to checksum (8-bit wrap, carry discarded).
- LOAD exit: 16th write → LOADED on the same edge; load_req=0 with fewer than 16 writes → LOADED (unwritten entries keep prior values). A strobe edge coinciding with load_req=0 is dropped.
- LOADED: run_req=1 → RUN; load_req=1 → LOAD.
- RUN: cpu_run=1; load_req=1 → LOAD (cpu_run low on that edge, CPU stops mid-program).
- Strobe edges outside LOAD are discarded; no queuing.
- rom_data reflects the array in all states, including during LOAD (CPU is stopped, so no hazard).
- Outputs are decodes of the registered state: loading=(LOAD), load_done=(LOADED), cpu_run=(RUN).

## Timing
- data_strobe passes through SYNC_STAGES flops, then one previous-value flop; edge pulse = sync_out & ~prev.
- With SYNC_STAGES=2: strobe first sampled high at edge E0 → pulse high between E1 and E2 → array write, byte_count and checksum update at E2. Latency SYNC_STAGES cycles from first sampling edge to write.
- data_in is sampled at the write edge; the driver holds it stable from before E0 through E2.
- Strobe high and low times each ≥ SYNC_STAGES+1 clk periods; shorter pulses may be lost.
- State transitions take effect one edge after the request level is sampled; cpu_run/loading/load_done change on that same edge.
- rom_data: zero-cycle combinational path from rom_addr and array flops; write at edge E becomes visible immediately after E.
- Reset asserted mid-load aborts the load and clears the array; release requires no strobe activity.

## Test plan
- Reset: assert rst_n=0 mid-RUN → cpu_run=0, byte_count=0, checksum=0x00, rom_data=0x00 for every rom_addr, state IDLE.
- Full load: load_req=1, strobe bytes 0x00..0x0F → load_done=1 after 16th write, byte_count=16, checksum=0x78, rom_data at addr 5 = 0x05; then run_req=1 → cpu_run=1 one edge later.
- Partial load: after full load of 0xFF×16, reload 3 bytes 0xA1,0xB2,0xC3, drop load_req → LOADED, byte_count=3, checksum=0x16, addr 2 = 0xC3, addr 3 = 0xFF.
- Checksum wrap: load 0x80,0x90 → checksum 0x10.
- Ignored strobes: strobe edges in IDLE, LOADED, RUN → array, byte_count, checksum unchanged; strobe pulse of 1 cycle in LOAD (SYNC_STAGES=2) must not cause a double write.
- Reload from RUN: load_req=1 while running → cpu_run=0 and loading=1 on next edge, byte_count=0; load_req and run_req both high in IDLE → LOAD.
